// File: rtl/demux_pkg.sv
// Shared select encoding and channel count for the 1-to-3 stream demux.
package demux_pkg;

  localparam logic [1:0] SEL_CH0  = 2'b00;
  localparam logic [1:0] SEL_CH1  = 2'b01;
  localparam logic [1:0] SEL_CH2  = 2'b10;
  localparam logic [1:0] SEL_DROP = 2'b11;

  localparam int NUM_CH = 3;

  typedef logic [NUM_CH:0] sel_oh_t;

  function automatic sel_oh_t sel_decode(
    input logic [1:0] sel
  );
    sel_oh_t oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small per-channel FIFO: register-array storage, head read from the
// array at the read pointer, so a pushed word is visible the next cycle.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_1to3.sv
// Routes one result stream to three buffered consumer channels;
// select 2'b11 discards the word and counts it.
module stream_demux_1to3
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_cnt
);

  sel_oh_t           sel_oh;
  logic              xfer;
  logic              drop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [WIDTH-1:0]  rdata [NUM_CH];

  assign sel_oh = sel_decode(in_sel);

  // Ready is a pure function of select and full flags, never of out ready.
  always_comb begin
    in_ready = 1'b0;
    unique case (1'b1)
      sel_oh[SEL_CH0]:  in_ready = ~full[0];
      sel_oh[SEL_CH1]:  in_ready = ~full[1];
      sel_oh[SEL_CH2]:  in_ready = ~full[2];
      sel_oh[SEL_DROP]: in_ready = 1'b1;
      default:          in_ready = 1'b0;
    endcase
  end

  assign xfer = in_valid & in_ready;
  assign drop = xfer & sel_oh[SEL_DROP];
  assign push = {NUM_CH{xfer}} & sel_oh[NUM_CH-1:0];
  assign pop  = {out2_ready, out1_ready, out0_ready} & ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stream_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[g]),
      .wdata(in_data),
      .pop  (pop[g]),
      .full (full[g]),
      .empty(empty[g]),
      .rdata(rdata[g])
    );
  end

  assign out0_data  = rdata[0];
  assign out1_data  = rdata[1];
  assign out2_data  = rdata[2];
  assign out0_valid = ~empty[0];
  assign out1_valid = ~empty[1];
  assign out2_valid = ~empty[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1to3.sv
// Randomized and directed bench for stream_demux_1to3 against a
// queue-based channel model.
module tb_stream_demux_1to3;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data, out2_data;
  logic             out0_valid, out1_valid, out2_valid;
  logic             out0_ready, out1_ready, out2_ready;
  logic             drop_pulse;
  logic [CNT_W-1:0] drop_cnt;

  logic [WIDTH-1:0] od [3];
  logic             ov [3];

  logic [31:0] q [3][$];
  int          exp_cnt;
  logic        exp_pulse;
  logic        last_acc;
  int          n_checks;
  int          n_errors;

  stream_demux_1to3 #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out2_data (out2_data),
    .out2_valid(out2_valid),
    .out2_ready(out2_ready),
    .drop_pulse(drop_pulse),
    .drop_cnt  (drop_cnt)
  );

  assign od[0] = out0_data;
  assign od[1] = out1_data;
  assign od[2] = out2_data;
  assign ov[0] = out0_valid;
  assign ov[1] = out1_valid;
  assign ov[2] = out2_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 3; c++) q[c].delete();
    exp_cnt   = 0;
    exp_pulse = 1'b0;
  endtask

  // One cycle: drive, compare against the model, advance the model.
  task automatic step(
    input logic [1:0]  s,
    input logic [31:0] d,
    input logic        v,
    input logic [2:0]  r
  );
    logic exp_rdy;
    in_sel   = s;
    in_data  = d;
    in_valid = v;
    {out2_ready, out1_ready, out0_ready} = r;
    #1;
    if (s == 2'd3) exp_rdy = 1'b1;
    else exp_rdy = (q[s].size() < DEPTH);
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    for (int c = 0; c < 3; c++) begin
      check($sformatf("out%0d_valid", c), {31'b0, ov[c]},
            {31'b0, q[c].size() > 0});
      if (q[c].size() > 0)
        check($sformatf("out%0d_data", c), od[c], q[c][0]);
    end
    check("drop_pulse", {31'b0, drop_pulse}, {31'b0, exp_pulse});
    check("drop_cnt", {24'b0, drop_cnt}, exp_cnt);
    last_acc = v && exp_rdy;
    for (int c = 0; c < 3; c++)
      if (q[c].size() > 0 && r[c]) void'(q[c].pop_front());
    exp_pulse = 1'b0;
    if (last_acc) begin
      if (s == 2'd3) begin
        exp_pulse = 1'b1;
        if (exp_cnt < CMAX) exp_cnt++;
      end else begin
        q[s].push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_clear();
    rst = 1'b1;
    in_data = '0;
    in_sel = 2'd0;
    in_valid = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    #2;
    check("rst_v0", {31'b0, out0_valid}, 32'd0);
    check("rst_v1", {31'b0, out1_valid}, 32'd0);
    check("rst_v2", {31'b0, out2_valid}, 32'd0);
    check("rst_d0", out0_data, 32'd0);
    check("rst_d1", out1_data, 32'd0);
    check("rst_d2", out2_data, 32'd0);
    check("rst_cnt", {24'b0, drop_cnt}, 32'd0);
    check("rst_pulse", {31'b0, drop_pulse}, 32'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("rst_ready_sel%0d", s), {31'b0, in_ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ch1 backpressure, then drain in order
    step(2'd1, 32'hA1, 1'b1, 3'b000);
    step(2'd1, 32'hA2, 1'b1, 3'b000);
    check("ch1_head_after_accept", out1_data, 32'hA1);
    step(2'd1, 32'hA3, 1'b1, 3'b000);
    check("ch1_third_refused", {31'b0, last_acc}, 32'd0);
    step(2'd1, 32'hA3, 1'b1, 3'b010);
    step(2'd1, 32'hA3, 1'b1, 3'b010);
    check("ch1_retry_accepted", {31'b0, last_acc}, 32'd1);
    for (int i = 0; i < 3; i++) step(2'd0, 32'h0, 1'b0, 3'b010);

    // interleaved channels, all ready
    step(2'd0, 32'h10, 1'b1, 3'b111);
    step(2'd2, 32'h20, 1'b1, 3'b111);
    step(2'd0, 32'h11, 1'b1, 3'b111);
    step(2'd3, 32'h0, 1'b0, 3'b111);
    step(2'd3, 32'h0, 1'b0, 3'b111);

    // ch2 full with simultaneous pop: push refused, retried next cycle
    step(2'd2, 32'h31, 1'b1, 3'b000);
    step(2'd2, 32'h32, 1'b1, 3'b000);
    step(2'd2, 32'h33, 1'b1, 3'b100);
    check("ch2_full_pop_refused", {31'b0, last_acc}, 32'd0);
    step(2'd2, 32'h33, 1'b1, 3'b100);
    check("ch2_retry_accepted", {31'b0, last_acc}, 32'd1);
    for (int i = 0; i < 3; i++) step(2'd0, 32'h0, 1'b0, 3'b100);

    // saturating drop counter
    for (int i = 0; i < 260; i++) step(2'd3, $urandom, 1'b1, 3'b111);
    step(2'd3, 32'h0, 1'b0, 3'b111);
    check("drop_cnt_sat", {24'b0, drop_cnt}, 32'd255);
    step(2'd3, 32'h0, 1'b0, 3'b111);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(2'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)));
    end

    // asynchronous reset with words buffered in ch0
    for (int i = 0; i < 3; i++) step(2'd0, 32'h0, 1'b0, 3'b111);
    step(2'd0, 32'hB0, 1'b1, 3'b000);
    step(2'd0, 32'hB1, 1'b1, 3'b000);
    check("pre_rst_v0", {31'b0, out0_valid}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_v0", {31'b0, out0_valid}, 32'd0);
    check("async_rst_d0", out0_data, 32'd0);
    check("async_rst_cnt", {24'b0, drop_cnt}, 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(2'd0, 32'h0, 1'b0, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to3.md
Name: stream_demux_1to3

Overview:
- Routes a single 32-bit result stream to one of three consumer channels, chosen by a 2-bit select. It is the distribution-side counterpart of the 3-to-1 select mux in the ALU datapath.
- Each destination channel has its own small FIFO, so one stalled consumer never corrupts the others' ordering.
- Select code 2'b11 is unmapped: the word is accepted and discarded, and a saturating drop counter and a one-cycle pulse report it.
- Sits between the ALU result stage and three downstream consumers (e.g. register write-back, store path, debug tap).

Parameters:
- WIDTH, 32, data width of input and all output channels.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  payload.
- in_sel  input  2  destination: 00 ch0, 01 ch1, 10 ch2, 11 drop.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- out0_data / out1_data / out2_data  output  WIDTH  head-of-FIFO data per channel.
- out0_valid / out1_valid / out2_valid  output  1  channel FIFO non-empty.
- out0_ready / out1_ready / out2_ready  input  1  consumer takes head this cycle.
- drop_pulse  output  1  high for exactly the cycle after a sel=11 transfer.
- drop_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (async assert, sync-safe release):
  - All FIFOs empty; outN_valid=0; outN_data=0.
  - drop_cnt=0; drop_pulse=0.
  - in_ready follows its combinational rule and is already 1 for any select during reset, because all FIFOs are empty.
- Reset mid-operation: all buffered words are discarded and the pointers cleared immediately; nothing is emitted afterwards.
- Input acceptance:
  - in_ready is combinational from in_sel and FIFO full flags:
    - sel 00/01/10: in_ready = !full[sel].
    - sel 11: in_ready = 1.
  - Transfer occurs when in_valid & in_ready.
  - in_ready never depends on in_valid or on outN_ready, so there is no combinational path from out ready to in ready.
- Full FIFO with simultaneous pop: the push is still refused that cycle (no pass-through). The producer retries next cycle, when full has cleared.
- Latency: a word accepted in cycle t appears at outN_data/outN_valid in cycle t+1, with no bypass.
- Output handshake:
  - A pop occurs when outN_valid & outN_ready.
  - outN_data and outN_valid are held stable while outN_valid & !outN_ready.
  - Per-channel order is strictly FIFO.
  - There is no ordering guarantee across channels.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged, and both pointers advance modulo DEPTH (wrap-around).
- Push into an empty FIFO while the consumer is ready: the word still becomes visible only at t+1.
- Drop path:
  - Each sel=11 transfer increments drop_cnt, which saturates at 2^CNT_W-1 and never wraps.
  - drop_pulse=1 in the following cycle; back-to-back drops give a continuous high.
- outN_ready while outN_valid=0 is ignored (no underflow). The in_valid=0 cycle is ignored regardless of in_sel.
- Arithmetic: pointer width is log2(DEPTH); occupancy width is log2(DEPTH)+1.

Decomposition:
- Shared package demux_pkg holds:
  - Select encoding constants SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_CH2=2'b10, SEL_DROP=2'b11.
  - Channel count constant NUM_CH=3.
- One sub-module, stream_fifo (WIDTH, DEPTH):
  - Synchronous push/pop with full/empty flags and registered head output.
  - Instantiated three times.
- Top level holds the select decode, ready mux and drop counter.

Test Plan:
- Reset then idle -> all outN_valid=0, outN_data=0, drop_cnt=0; in_ready=1 for every sel.
- Push 0xA1, 0xA2, 0xA3 to ch1 with out1_ready=0, DEPTH=2 -> first two accepted; in_ready=0 on the third; out1_data=0xA1 one cycle after the first accept. Release out1_ready -> 0xA1, 0xA2, then 0xA3 delivered in order.
- Interleave pushes ch0=0x10, ch2=0x20, ch0=0x11 with all readys high -> each appears on its own channel exactly one cycle after its accept; no cross-channel leakage.
- Hold out2 full and pop in the same cycle as a push to ch2 -> push refused that cycle, accepted the next; no data lost or duplicated.
- Send 260 words with sel=11, CNT_W=8 -> drop_cnt stops at 255; drop_pulse high each following cycle; no outN_valid asserted.
- Assert rst with two words buffered in ch0 -> out0_valid=0 immediately (asynchronous); after release, no stale word is emitted.
